// File: rtl/count_load_sequencer_if.sv
// Command bus into the count/load sequencer: one {clear, data} command per
// valid/ready handshake.
interface count_load_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_clear;
   logic [3:0] cmd_data;

   modport master (output cmd_valid, cmd_clear, cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, cmd_clear, cmd_data, output cmd_ready);
endinterface

// File: rtl/count_load_sequencer.sv
// Buffers load/clear commands, issues them to a downstream counter as
// spaced single-cycle pulses and checks the counter value read back.
//
// state   | meaning
// S_IDLE  | waiting for a FIFO entry; head decoded into registered pulse here
// S_ISSUE | ctr_load or ctr_rst high for this cycle; head popped at its end
// S_CHECK | ctr_count compared with expected; result registered
// S_WAIT  | GAP idle cycles before the next issue
module count_load_sequencer #(
   parameter int DEPTH  = 4,
   parameter int GAP    = 2,
   parameter int OFFSET = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   count_load_sequencer_if.slave     cmd,
   output logic                      ctr_rst,
   output logic                      ctr_load,
   output logic [3:0]                ctr_data,
   input  logic [3:0]                ctr_count,
   output logic                      chk_valid,
   output logic                      chk_err,
   output logic [7:0]                err_cnt,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      busy
);

   localparam int              PW     = $clog2(DEPTH);
   localparam int              LW     = PW + 1;
   localparam logic [3:0]      OFF4   = 4'(OFFSET);
   localparam logic [3:0]      GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam logic [LW-1:0]   FULL   = LW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [4:0]      mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [3:0]      exp_q, exp_d;
   logic [3:0]      wait_q, wait_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            ctr_rst_q, ctr_rst_d;
   logic            ctr_load_q, ctr_load_d;
   logic [3:0]      ctr_data_q, ctr_data_d;
   logic            chk_valid_q, chk_valid_d;
   logic            chk_err_q, chk_err_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic            busy_q, busy_d;
   logic            push, pop;
   logic [4:0]      head;

   always_comb begin
      push        = cmd.cmd_valid && cmd_ready_q;
      pop         = (state_q == S_ISSUE);
      head        = mem_q[rd_ptr_q];
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      exp_d       = exp_q;
      wait_d      = wait_q;
      ctr_rst_d   = 1'b0;
      ctr_load_d  = 1'b0;
      ctr_data_d  = ctr_data_q;
      chk_valid_d = 1'b0;
      chk_err_d   = 1'b0;
      err_cnt_d   = err_cnt_q;

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (level_q != '0) begin
               state_d = S_ISSUE;
               if (head[4]) begin
                  ctr_rst_d  = 1'b1;
                  ctr_data_d = 4'd0;
                  exp_d      = 4'd0;
               end else begin
                  ctr_load_d = 1'b1;
                  ctr_data_d = head[3:0];
                  exp_d      = head[3:0] + OFF4;
               end
            end
         end
         S_ISSUE: state_d = S_CHECK;
         S_CHECK: begin
            chk_valid_d = 1'b1;
            chk_err_d   = (ctr_count != exp_q);
            if ((ctr_count != exp_q) && (err_cnt_q != 8'hFF))
               err_cnt_d = err_cnt_q + 8'd1;
            if (GAP > 0) begin
               state_d = S_WAIT;
               wait_d  = GAP_M1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (wait_q == 4'd0) state_d = S_IDLE;
            else                wait_d  = wait_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // Ready is registered from the next level, so a pop at full never frees a slot the same cycle.
      cmd_ready_d = (level_d != FULL);
      busy_d      = (state_d != S_IDLE) || (level_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         exp_q       <= 4'd0;
         wait_q      <= 4'd0;
         cmd_ready_q <= 1'b0;
         ctr_rst_q   <= 1'b1;
         ctr_load_q  <= 1'b0;
         ctr_data_q  <= 4'd0;
         chk_valid_q <= 1'b0;
         chk_err_q   <= 1'b0;
         err_cnt_q   <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         exp_q       <= exp_d;
         wait_q      <= wait_d;
         cmd_ready_q <= cmd_ready_d;
         ctr_rst_q   <= ctr_rst_d;
         ctr_load_q  <= ctr_load_d;
         ctr_data_q  <= ctr_data_d;
         chk_valid_q <= chk_valid_d;
         chk_err_q   <= chk_err_d;
         err_cnt_q   <= err_cnt_d;
         busy_q      <= busy_d;
      end
   end

   // Storage needs no reset: emptiness is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd.cmd_clear, cmd.cmd_data};
   end

   assign cmd.cmd_ready = cmd_ready_q;
   assign ctr_rst       = ctr_rst_q;
   assign ctr_load      = ctr_load_q;
   assign ctr_data      = ctr_data_q;
   assign chk_valid     = chk_valid_q;
   assign chk_err       = chk_err_q;
   assign err_cnt       = err_cnt_q;
   assign level         = level_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_count_load_sequencer.sv
// Scoreboard bench for count_load_sequencer: instance A (OFFSET=2) drives a
// counter model, instance B (OFFSET=3) is checked against a fixed count.
module tb_count_load_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   count_load_sequencer_if cif_a ();
   count_load_sequencer_if cif_b ();

   logic       ctr_rst_a, ctr_load_a, chk_valid_a, chk_err_a, busy_a;
   logic [3:0] ctr_data_a, ctr_count_a;
   logic [7:0] err_cnt_a;
   logic [2:0] level_a;
   logic       ctr_rst_b, ctr_load_b, chk_valid_b, chk_err_b, busy_b;
   logic [3:0] ctr_data_b, ctr_count_b;
   logic [7:0] err_cnt_b;
   logic [2:0] level_b;

   count_load_sequencer #(.DEPTH(4), .GAP(2), .OFFSET(2)) u_dut_a (
      .clk(clk), .rst(rst), .cmd(cif_a.slave),
      .ctr_rst(ctr_rst_a), .ctr_load(ctr_load_a), .ctr_data(ctr_data_a),
      .ctr_count(ctr_count_a), .chk_valid(chk_valid_a), .chk_err(chk_err_a),
      .err_cnt(err_cnt_a), .level(level_a), .busy(busy_a));

   count_load_sequencer #(.DEPTH(4), .GAP(2), .OFFSET(3)) u_dut_b (
      .clk(clk), .rst(rst), .cmd(cif_b.slave),
      .ctr_rst(ctr_rst_b), .ctr_load(ctr_load_b), .ctr_data(ctr_data_b),
      .ctr_count(ctr_count_b), .chk_valid(chk_valid_b), .chk_err(chk_err_b),
      .err_cnt(err_cnt_b), .level(level_b), .busy(busy_b));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct { logic clr; logic [3:0] data; logic bad; int t_acc; } cmd_t;
   typedef struct { logic bad; int t_acc; } chk_t;
   cmd_t cmd_q[$];
   chk_t chk_q[$];

   int   cyc = 0;
   logic [3:0] cnt_a = 4'd0;
   logic bad_now = 1'b0;
   logic burst = 1'b0;

   // Downstream counter model: sync clear, load adds OFFSET, plus an optional planted error.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ctr_rst_a)       cnt_a <= {3'b000, bad_now};
      else if (ctr_load_a) cnt_a <= ctr_data_a + 4'd2 + {3'b000, bad_now};
   end
   assign ctr_count_a = cnt_a;

   cmd_t e;
   chk_t c;
   int   last_pulse  = -1;
   logic last_burst  = 1'b0;
   int   exp_err_cnt = 0;
   logic saw_full    = 1'b0;

   always @(negedge clk) begin
      bad_now = 1'b0;
      if (!rst) begin
         chk_q.delete();
         last_pulse  = -1;
         last_burst  = 1'b0;
         exp_err_cnt = 0;
      end else begin
         if (ctr_load_a || ctr_rst_a) begin
            check_val("pulse_exclusive", ctr_load_a && ctr_rst_a, 0);
            if (cmd_q.size() == 0) begin
               check_val("unexpected_pulse", cmd_q.size(), 1);
            end else begin
               e = cmd_q.pop_front();
               check_val("pulse_rst", ctr_rst_a, e.clr);
               check_val("pulse_load", ctr_load_a, !e.clr);
               check_val("pulse_data", ctr_data_a, e.clr ? 4'd0 : e.data);
               bad_now = e.bad;
               chk_q.push_back('{e.bad, e.t_acc});
               if (last_pulse >= 0) begin
                  check_val("min_spacing", (cyc - last_pulse) >= 5, 1);
                  if (burst && last_burst) check_val("burst_spacing", cyc - last_pulse, 5);
               end
               last_pulse = cyc;
               last_burst = burst;
            end
         end
         if (chk_valid_a) begin
            if (chk_q.size() == 0) begin
               check_val("unexpected_chk_valid", chk_q.size(), 1);
            end else begin
               c = chk_q.pop_front();
               if (c.bad && exp_err_cnt < 255) exp_err_cnt++;
               check_val("chk_err", chk_err_a, c.bad);
               check_val("err_cnt", err_cnt_a, exp_err_cnt);
               if (c.t_acc >= 0) check_val("latency", cyc - c.t_acc, 4);
            end
         end
         if (level_a == 3'd4) begin
            check_val("ready_at_full", cif_a.cmd_ready, 0);
            saw_full = 1'b1;
         end
      end
   end

   task automatic send_a(input logic clr, input logic [3:0] d, input logic bad, input logic timed);
      int k = 0;
      cif_a.cmd_valid = 1'b1;
      cif_a.cmd_clear = clr;
      cif_a.cmd_data  = d;
      while (!cif_a.cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_val("ready_wait", k < 50, 1);
      cmd_q.push_back('{clr, d, bad, timed ? cyc : -1});
      @(negedge clk);
      cif_a.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle_a();
      int k = 0;
      while (!(busy_a == 1'b0 && cmd_q.size() == 0 && chk_q.size() == 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_val("idle_reached", k < 200, 1);
   endtask

   task automatic run_b(input logic [3:0] cnt, input logic [3:0] d, input logic exp_err,
                        input logic [7:0] exp_cnt);
      int  k    = 0;
      logic seen = 1'b0;
      ctr_count_b     = cnt;
      cif_b.cmd_valid = 1'b1;
      cif_b.cmd_clear = 1'b0;
      cif_b.cmd_data  = d;
      @(negedge clk);
      cif_b.cmd_valid = 1'b0;
      while (!chk_valid_b && k < 20) begin
         if (ctr_load_b) begin
            check_val("b_pulse_data", ctr_data_b, d);
            seen = 1'b1;
         end
         @(negedge clk);
         k++;
      end
      check_val("b_load_seen", seen, 1);
      check_val("b_chk_valid", chk_valid_b, 1);
      check_val("b_chk_err", chk_err_b, exp_err);
      check_val("b_err_cnt", err_cnt_b, exp_cnt);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [3:0] burst_data [6];
   initial begin
      int k;
      burst_data = '{4'h3, 4'hA, 4'hF, 4'h0, 4'h7, 4'hC};
      rst = 1'b0;
      cif_a.cmd_valid = 1'b0; cif_a.cmd_clear = 1'b0; cif_a.cmd_data = 4'd0;
      cif_b.cmd_valid = 1'b0; cif_b.cmd_clear = 1'b0; cif_b.cmd_data = 4'd0;
      ctr_count_b = 4'd0;
      repeat (3) @(negedge clk);
      check_val("rst_ctr_rst", ctr_rst_a, 1);
      check_val("rst_cmd_ready", cif_a.cmd_ready, 0);
      check_val("rst_ctr_load", ctr_load_a, 0);
      check_val("rst_level", level_a, 0);
      check_val("rst_busy", busy_a, 0);
      #2 rst = 1'b1;
      @(negedge clk);
      check_val("rel_ctr_rst", ctr_rst_a, 0);
      check_val("rel_cmd_ready", cif_a.cmd_ready, 1);
      check_val("rel_ctr_load", ctr_load_a, 0);
      check_val("rel_ctr_data", ctr_data_a, 0);
      check_val("rel_chk_valid", chk_valid_a, 0);
      check_val("rel_chk_err", chk_err_a, 0);
      check_val("rel_err_cnt", err_cnt_a, 0);
      check_val("rel_level", level_a, 0);
      check_val("rel_busy", busy_a, 0);
      check_val("rel_b_ctr_rst", ctr_rst_b, 0);
      check_val("rel_b_ready", cif_b.cmd_ready, 1);
      check_val("rel_b_level", level_b, 0);
      check_val("rel_b_busy", busy_b, 0);

      send_a(1'b0, 4'd5, 1'b0, 1'b1);
      wait_idle_a();
      send_a(1'b0, 4'd6, 1'b1, 1'b0);
      wait_idle_a();

      burst = 1'b1;
      for (int i = 0; i < 6; i++) send_a(1'b0, burst_data[i], 1'b0, 1'b0);
      wait_idle_a();
      burst = 1'b0;
      check_val("level_reached_full", saw_full, 1);

      send_a(1'b0, 4'd9, 1'b0, 1'b0);
      send_a(1'b1, 4'd4, 1'b0, 1'b0);
      wait_idle_a();

      send_a(1'b0, 4'd8, 1'b0, 1'b0);
      k = 0;
      while (!ctr_load_a && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("abort_issue_seen", ctr_load_a, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check_val("abort_chk_valid", chk_valid_a, 0);
      check_val("abort_level", level_a, 0);
      check_val("abort_ctr_rst", ctr_rst_a, 1);
      check_val("abort_busy", busy_a, 0);
      repeat (2) @(negedge clk);
      check_val("abort_no_chk_valid", chk_valid_a, 0);
      #2 rst = 1'b1;
      @(negedge clk);
      check_val("rerel_ctr_rst", ctr_rst_a, 0);
      check_val("rerel_err_cnt", err_cnt_a, 0);
      check_val("rerel_cmd_ready", cif_a.cmd_ready, 1);
      send_a(1'b0, 4'd3, 1'b0, 1'b1);
      wait_idle_a();

      run_b(4'd1, 4'd14, 1'b0, 8'd0);
      run_b(4'd2, 4'd14, 1'b1, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/count_load_sequencer.md
# count_load_sequencer

Command front-end that sits directly upstream of the `counter` / `counter_wrapper` / `multi_counter` hierarchy and drives its `rst`, `load` and `data` inputs. It buffers load/clear commands in a small FIFO and issues them to the counter as single-cycle pulses with a programmable minimum spacing. One cycle after each issue it reads back `count` and checks it against the expected value, including the data offset added by the instantiated path. It reports each check result and keeps a saturating error count.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `GAP`, 2: idle cycles inserted after each check; 0–15.
- `OFFSET`, 0: value the downstream path adds to loaded data (mod 16). Use 2 for `multi_counter`, 3 for a bare `counter_wrapper`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_clear`  in  1  1 = clear command, 0 = load command.
- `cmd_data`  in  4  load value; ignored when `cmd_clear` is 1.
- `ctr_rst`  out  1  to counter `rst` (sync, active-high).
- `ctr_load`  out  1  to counter `load`.
- `ctr_data`  out  4  to counter `data`.
- `ctr_count`  in  4  from counter `count`.
- `chk_valid`  out  1  one-cycle pulse: check result valid.
- `chk_err`  out  1  mismatch flag, qualified by `chk_valid`.
- `err_cnt`  out  8  saturating mismatch count.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- **FIFO**
  - Push on `cmd_valid && cmd_ready`; entry = {`cmd_clear`, `cmd_data`}.
  - `cmd_ready = rst && (level != DEPTH)`. It does not depend on a same-cycle pop, so at full no push occurs even when a pop happens that cycle.
  - Simultaneous push and pop: `level` is unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states**
  - IDLE: if FIFO non-empty → ISSUE.
  - ISSUE: pop head. Load entry: `ctr_load`=1, `ctr_data`=data. Clear entry: `ctr_rst`=1, `ctr_data`=0. Latch expected = clear ? 0 : (data + OFFSET) mod 16 (4-bit wrap). → CHECK.
  - CHECK: compare `ctr_count` with expected. Pulse `chk_valid`; set `chk_err`=(mismatch). On mismatch, `err_cnt` increments and saturates at 255. → WAIT if GAP>0, else IDLE.
  - WAIT: count GAP cycles → IDLE.
- All outputs are registered. `ctr_load` and `ctr_rst` are never both 1.
- Outside ISSUE: `ctr_load`=0, `ctr_data` holds its last value. `ctr_rst`=0 except as described under Reset.
- **Reset** (`rst` low, asynchronous):
  - FIFO is emptied and the FSM goes to IDLE.
  - `cmd_ready`=0, `ctr_load`=0, `ctr_data`=0, `chk_valid`=0, `chk_err`=0, `err_cnt`=0, `level`=0, `busy`=0.
  - `ctr_rst`=1 so the downstream counter is held in reset. It deasserts on the first rising edge after `rst` rises.
  - Reset during ISSUE/CHECK/WAIT aborts the command: no `chk_valid` is produced and the popped entry is lost.

## Timing
- Push at edge N → IDLE sees non-empty in cycle N+1 → ISSUE in cycle N+2.
- Counter samples `ctr_load` at the end of ISSUE. `ctr_count` equals the loaded value during CHECK, and `chk_valid` is asserted in the cycle after CHECK.
- Minimum spacing between successive `ctr_load`/`ctr_rst` pulses: GAP+3 cycles.
- Latency from accepted command to `chk_valid`: 4 cycles when the FSM is idle.
- `level` updates one cycle after a push or pop.

## Test plan
- Reset release, OFFSET=2: `ctr_rst`=1 during reset and 0 one cycle after release. All other outputs are 0 and `cmd_ready`=1 after release.
- Single load, `cmd_data`=5, OFFSET=2, counter model attached: `ctr_load` pulses with `ctr_data`=5, then `chk_valid`=1, `chk_err`=0 (`ctr_count`=7), `err_cnt`=0.
- Wrap: `cmd_data`=14, OFFSET=3 → expected 1. Counter returns 1 → `chk_err`=0. Forced `ctr_count`=2 → `chk_err`=1, `err_cnt`=1.
- Back-pressure, DEPTH=4, GAP=2: push 6 back-to-back commands. `cmd_ready` drops when `level`=4. Load pulses are exactly 5 cycles apart, and all 6 are issued in order.
- Clear command after load 9: `ctr_rst` pulses with `ctr_load`=0, and the check expects 0 → `chk_err`=0.
- Reset asserted during CHECK: no `chk_valid`, `level`=0, `ctr_rst`=1. After release, a new load of 3 works normally.
